// File: rtl/dp_tap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dp_tap_ctrl: oversampled IEEE 1149.1 TAP controller for the debug port.    |
// | Optional TRST support is enabled by defining DP_TAP_TRST_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dp_tap_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       iclk,
  input  logic       iresetn,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
`ifdef DP_TAP_TRST_EN
  input  logic       trstn,
`endif
  output logic       tdo,
  output logic       tdo_oe,
  output logic       sdi,
  input  logic       ir_sdo,
  input  logic       dr_sdo,
  output logic       shift_ir,
  output logic       clk_ir,
  output logic       update_ir,
  output logic       shift_dr,
  output logic       clk_dr,
  output logic       update_dr,
  output logic       tlr,
  output logic       rti,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  logic [SYNC_STAGES-1:0] tck_sync_q, tck_sync_d;
  logic [SYNC_STAGES-1:0] tms_sync_q, tms_sync_d;
  logic [SYNC_STAGES-1:0] tdi_sync_q, tdi_sync_d;
`ifdef DP_TAP_TRST_EN
  logic [SYNC_STAGES-1:0] trstn_sync_q, trstn_sync_d;
  logic                   trstn_s;
`endif
  logic tck_prev_q, tck_prev_d;
  logic tck_s, tms_s, tdi_s, tck_rise, tck_fall;

  tap_state_e state_q, state_d, state_nxt;
  logic clk_ir_q, clk_ir_d, shift_ir_q, shift_ir_d, update_ir_q, update_ir_d;
  logic clk_dr_q, clk_dr_d, shift_dr_q, shift_dr_d, update_dr_q, update_dr_d;
  logic tdo_q, tdo_d, tdo_oe_q, tdo_oe_d, sdi_q, sdi_d;
  logic tlr_q, tlr_d, rti_q, rti_d;

  assign tck_s    = tck_sync_q[SYNC_STAGES-1];
  assign tms_s    = tms_sync_q[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev_q;
  assign tck_fall = ~tck_s & tck_prev_q;
`ifdef DP_TAP_TRST_EN
  assign trstn_s  = trstn_sync_q[SYNC_STAGES-1];
`endif

  always_comb begin
    tck_sync_d = {tck_sync_q[SYNC_STAGES-2:0], tck};
    tms_sync_d = {tms_sync_q[SYNC_STAGES-2:0], tms};
    tdi_sync_d = {tdi_sync_q[SYNC_STAGES-2:0], tdi};
`ifdef DP_TAP_TRST_EN
    trstn_sync_d = {trstn_sync_q[SYNC_STAGES-2:0], trstn};
`endif
    tck_prev_d = tck_s;
  end

  // IEEE 1149.1 state graph, evaluated against the synchronized TMS
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      TLR:     state_nxt = tms_s ? TLR    : RTI;
      RTI:     state_nxt = tms_s ? SEL_DR : RTI;
      SEL_DR:  state_nxt = tms_s ? SEL_IR : CAP_DR;
      CAP_DR:  state_nxt = tms_s ? EX1_DR : SH_DR;
      SH_DR:   state_nxt = tms_s ? EX1_DR : SH_DR;
      EX1_DR:  state_nxt = tms_s ? UPD_DR : PAU_DR;
      PAU_DR:  state_nxt = tms_s ? EX2_DR : PAU_DR;
      EX2_DR:  state_nxt = tms_s ? UPD_DR : SH_DR;
      UPD_DR:  state_nxt = tms_s ? SEL_DR : RTI;
      SEL_IR:  state_nxt = tms_s ? TLR    : CAP_IR;
      CAP_IR:  state_nxt = tms_s ? EX1_IR : SH_IR;
      SH_IR:   state_nxt = tms_s ? EX1_IR : SH_IR;
      EX1_IR:  state_nxt = tms_s ? UPD_IR : PAU_IR;
      PAU_IR:  state_nxt = tms_s ? EX2_IR : PAU_IR;
      EX2_IR:  state_nxt = tms_s ? UPD_IR : SH_IR;
      UPD_IR:  state_nxt = tms_s ? SEL_DR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    clk_ir_d    = 1'b0;
    clk_dr_d    = 1'b0;
    update_ir_d = 1'b0;
    update_dr_d = 1'b0;
    shift_ir_d  = shift_ir_q;
    shift_dr_d  = shift_dr_q;
    tdo_d       = tdo_q;
    tdo_oe_d    = tdo_oe_q;
    sdi_d       = sdi_q;

    // Strobes on the rise are decoded from the state being left
    if (tck_rise) begin
      state_d    = state_nxt;
      clk_ir_d   = (state_q == CAP_IR) || (state_q == SH_IR);
      shift_ir_d = (state_q == SH_IR);
      clk_dr_d   = (state_q == CAP_DR) || (state_q == SH_DR);
      shift_dr_d = (state_q == SH_DR);
      sdi_d      = tdi_s;
    end

    if (tck_fall) begin
      update_ir_d = (state_q == UPD_IR);
      update_dr_d = (state_q == UPD_DR);
      tdo_oe_d    = (state_q == SH_IR) || (state_q == SH_DR);
      if (state_q == SH_IR)      tdo_d = ir_sdo;
      else if (state_q == SH_DR) tdo_d = dr_sdo;
    end

`ifdef DP_TAP_TRST_EN
    if (!trstn_s) begin
      state_d     = TLR;
      clk_ir_d    = 1'b0;
      clk_dr_d    = 1'b0;
      shift_ir_d  = 1'b0;
      shift_dr_d  = 1'b0;
      update_ir_d = 1'b0;
      update_dr_d = 1'b0;
      tdo_oe_d    = 1'b0;
    end
`endif

    tlr_d = (state_d == TLR);
    rti_d = (state_d == RTI);
  end

  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      tck_sync_q   <= '0;
      tms_sync_q   <= '1;
      tdi_sync_q   <= '0;
`ifdef DP_TAP_TRST_EN
      trstn_sync_q <= '0;
`endif
      tck_prev_q   <= 1'b0;
      state_q      <= TLR;
      clk_ir_q     <= 1'b0;
      shift_ir_q   <= 1'b0;
      update_ir_q  <= 1'b0;
      clk_dr_q     <= 1'b0;
      shift_dr_q   <= 1'b0;
      update_dr_q  <= 1'b0;
      tdo_q        <= 1'b0;
      tdo_oe_q     <= 1'b0;
      sdi_q        <= 1'b0;
      tlr_q        <= 1'b1;
      rti_q        <= 1'b0;
    end else begin
      tck_sync_q   <= tck_sync_d;
      tms_sync_q   <= tms_sync_d;
      tdi_sync_q   <= tdi_sync_d;
`ifdef DP_TAP_TRST_EN
      trstn_sync_q <= trstn_sync_d;
`endif
      tck_prev_q   <= tck_prev_d;
      state_q      <= state_d;
      clk_ir_q     <= clk_ir_d;
      shift_ir_q   <= shift_ir_d;
      update_ir_q  <= update_ir_d;
      clk_dr_q     <= clk_dr_d;
      shift_dr_q   <= shift_dr_d;
      update_dr_q  <= update_dr_d;
      tdo_q        <= tdo_d;
      tdo_oe_q     <= tdo_oe_d;
      sdi_q        <= sdi_d;
      tlr_q        <= tlr_d;
      rti_q        <= rti_d;
    end
  end

  assign state     = state_q;
  assign tlr       = tlr_q;
  assign rti       = rti_q;
  assign clk_ir    = clk_ir_q;
  assign shift_ir  = shift_ir_q;
  assign update_ir = update_ir_q;
  assign clk_dr    = clk_dr_q;
  assign shift_dr  = shift_dr_q;
  assign update_dr = update_dr_q;
  assign tdo       = tdo_q;
  assign tdo_oe    = tdo_oe_q;
  assign sdi       = sdi_q;

endmodule
`default_nettype wire

// File: tb/tb_dp_tap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dp_tap_ctrl: scoreboard bench for dp_tap_ctrl with directed TAP walks.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dp_tap_ctrl;

  logic       iclk = 1'b0;
  logic       iresetn = 1'b0;
  logic       tck = 1'b0, tms = 1'b1, tdi = 1'b0, trstn = 1'b1;
  logic       ir_sdo = 1'b0, dr_sdo = 1'b0;
  logic       tdo, tdo_oe, sdi, shift_ir, clk_ir, update_ir;
  logic       shift_dr, clk_dr, update_dr, tlr, rti;
  logic [3:0] state;

  always #5 iclk = ~iclk;

  dp_tap_ctrl #(.SYNC_STAGES(2)) dut (
    .iclk(iclk), .iresetn(iresetn), .tck(tck), .tms(tms), .tdi(tdi),
`ifdef DP_TAP_TRST_EN
    .trstn(trstn),
`endif
    .tdo(tdo), .tdo_oe(tdo_oe), .sdi(sdi), .ir_sdo(ir_sdo), .dr_sdo(dr_sdo),
    .shift_ir(shift_ir), .clk_ir(clk_ir), .update_ir(update_ir),
    .shift_dr(shift_dr), .clk_dr(clk_dr), .update_dr(update_dr),
    .tlr(tlr), .rti(rti), .state(state)
  );

  int checks = 0;
  int errors = 0;

  // Expected events: state changes, clk pulses {ir,dr,shift_ir,shift_dr,sdi},
  // update pulses {ir,dr}, and {tdo_oe,tdo} changes
  logic [3:0] q_state[$];
  logic [4:0] q_clk[$];
  logic [1:0] q_upd[$];
  logic [1:0] q_tdo[$];

  logic [3:0] model_state = 4'hF;
  logic [1:0] model_pair  = 2'b00;

  logic [3:0] mon_state = 4'hF;
  logic [1:0] mon_pair  = 2'b00;
  logic [3:0] exp_s;
  logic [4:0] exp_c;
  logic [1:0] exp_u, exp_t;

  always @(negedge iclk) begin
    if (!iresetn) begin
      mon_state = 4'hF;
      mon_pair  = 2'b00;
    end else begin
      if (state !== mon_state) begin
        mon_state = state;
        checks++;
        if (q_state.size() == 0) begin
          errors++;
          $display("FAIL state_evt unexpected state=%h", state);
        end else begin
          exp_s = q_state.pop_front();
          if (state !== exp_s || tlr !== (exp_s == 4'hF) || rti !== (exp_s == 4'hC)) begin
            errors++;
            $display("FAIL state_evt got state=%h tlr=%b rti=%b want state=%h", state, tlr, rti, exp_s);
          end
        end
      end
      if (clk_ir || clk_dr) begin
        checks++;
        if (q_clk.size() == 0) begin
          errors++;
          $display("FAIL clk_evt unexpected clk_ir=%b clk_dr=%b", clk_ir, clk_dr);
        end else begin
          exp_c = q_clk.pop_front();
          if ({clk_ir, clk_dr, shift_ir, shift_dr, sdi} !== exp_c) begin
            errors++;
            $display("FAIL clk_evt got {clk_ir,clk_dr,sh_ir,sh_dr,sdi}=%b want %b",
                     {clk_ir, clk_dr, shift_ir, shift_dr, sdi}, exp_c);
          end
        end
      end
      if (update_ir || update_dr) begin
        checks++;
        if (q_upd.size() == 0) begin
          errors++;
          $display("FAIL upd_evt unexpected update_ir=%b update_dr=%b", update_ir, update_dr);
        end else begin
          exp_u = q_upd.pop_front();
          if ({update_ir, update_dr} !== exp_u) begin
            errors++;
            $display("FAIL upd_evt got %b want %b", {update_ir, update_dr}, exp_u);
          end
        end
      end
      if ({tdo_oe, tdo} !== mon_pair) begin
        mon_pair = {tdo_oe, tdo};
        checks++;
        if (q_tdo.size() == 0) begin
          errors++;
          $display("FAIL tdo_evt unexpected {tdo_oe,tdo}=%b", {tdo_oe, tdo});
        end else begin
          exp_t = q_tdo.pop_front();
          if ({tdo_oe, tdo} !== exp_t) begin
            errors++;
            $display("FAIL tdo_evt got {tdo_oe,tdo}=%b want %b", {tdo_oe, tdo}, exp_t);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  // One TCK period: nxt is the hand-computed state after the rise
  task automatic step(input logic t_ms, input logic t_di, input logic [3:0] nxt,
                      input logic i_sdo, input logic d_sdo);
    logic [3:0] p;
    logic [1:0] pair;
    p = model_state;
    tms = t_ms; tdi = t_di; ir_sdo = i_sdo; dr_sdo = d_sdo;
    if (nxt != p) q_state.push_back(nxt);
    if (p == 4'hE || p == 4'hA)      q_clk.push_back({1'b1, 1'b0, (p == 4'hA), 1'b0, t_di});
    else if (p == 4'h6 || p == 4'h2) q_clk.push_back({1'b0, 1'b1, 1'b0, (p == 4'h2), t_di});
    if (nxt == 4'hD)      q_upd.push_back(2'b10);
    else if (nxt == 4'h5) q_upd.push_back(2'b01);
    if (nxt == 4'hA)      pair = {1'b1, i_sdo};
    else if (nxt == 4'h2) pair = {1'b1, d_sdo};
    else                  pair = {1'b0, model_pair[0]};
    if (pair != model_pair) q_tdo.push_back(pair);
    model_pair  = pair;
    model_state = nxt;
    wait_clk(4);
    tck = 1'b1;
    wait_clk(8);
    tck = 1'b0;
    wait_clk(6);
  endtask

  initial begin
    // Reset held while TCK toggles
    tms = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_clk(3); tck = 1'b1;
      wait_clk(3); tck = 1'b0;
    end
    @(negedge iclk);
    chk("rst_state", {4'h0, state}, 8'h0F);
    chk("rst_tlr_rti", {6'h0, tlr, rti}, 8'h02);
    chk("rst_strobes", {2'b0, clk_ir, shift_ir, update_ir, clk_dr, shift_dr, update_dr}, 8'h00);
    chk("rst_tdo_sdi", {5'h0, tdo, tdo_oe, sdi}, 8'h00);
    @(posedge iclk); #1 iresetn = 1'b1;
    wait_clk(4);

    step(0, 0, 4'hC, 0, 0);
    // IR capture, 4-bit shift, update
    step(1, 0, 4'h7, 0, 0);
    step(1, 0, 4'h4, 0, 0);
    step(0, 0, 4'hE, 0, 0);
    step(0, 0, 4'hA, 1, 0);
    step(0, 1, 4'hA, 0, 0);
    step(0, 0, 4'hA, 1, 1);
    step(0, 1, 4'hA, 1, 0);
    step(1, 1, 4'h9, 0, 1);
    step(1, 0, 4'hD, 0, 1);
    step(0, 0, 4'hC, 0, 0);
    // DR path with pause loop
    step(1, 0, 4'h7, 1, 0);
    step(0, 0, 4'h6, 1, 0);
    step(0, 1, 4'h2, 1, 0);
    step(0, 0, 4'h2, 1, 1);
    step(1, 1, 4'h1, 1, 0);
    step(0, 0, 4'h3, 1, 0);
    step(0, 0, 4'h3, 1, 0);
    step(1, 0, 4'h0, 1, 0);
    step(0, 0, 4'h2, 1, 0);
    step(1, 1, 4'h1, 1, 1);
    step(1, 0, 4'h5, 0, 0);
    step(0, 0, 4'hC, 0, 0);
    // TMS-high reset from SH_DR
    step(1, 0, 4'h7, 0, 0);
    step(0, 0, 4'h6, 0, 0);
    step(0, 1, 4'h2, 0, 1);
    step(1, 0, 4'h1, 0, 0);
    step(1, 0, 4'h5, 0, 0);
    step(1, 0, 4'h7, 0, 0);
    step(1, 0, 4'h4, 0, 0);
    step(1, 0, 4'hF, 0, 0);
    chk("tms_rst_tlr", {7'h0, tlr}, 8'h01);
    step(0, 0, 4'hC, 0, 0);
`ifdef DP_TAP_TRST_EN
    step(1, 0, 4'h7, 0, 0);
    step(1, 0, 4'h4, 0, 0);
    step(0, 0, 4'hE, 0, 0);
    step(0, 0, 4'hA, 1, 0);
    step(0, 0, 4'hA, 1, 0);
    q_state.push_back(4'hF);
    q_tdo.push_back({1'b0, model_pair[0]});
    model_state = 4'hF;
    model_pair  = {1'b0, model_pair[0]};
    trstn = 1'b0;
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    chk("trst_state", {4'h0, state}, 8'h0F);
    chk("trst_shift_ir", {7'h0, shift_ir}, 8'h00);
    wait_clk(10);
    trstn = 1'b1;
    wait_clk(4);
    step(0, 0, 4'hC, 0, 0);
`endif
    // Asynchronous reset in the middle of a DR shift
    step(1, 0, 4'h7, 0, 0);
    step(0, 0, 4'h6, 0, 0);
    step(0, 0, 4'h2, 0, 1);
    wait_clk(10);
    chk("q_state_empty", q_state.size(), 8'h00);
    chk("q_clk_empty", q_clk.size(), 8'h00);
    chk("q_upd_empty", q_upd.size(), 8'h00);
    chk("q_tdo_empty", q_tdo.size(), 8'h00);
    @(posedge iclk); #2 iresetn = 1'b0;
    #1;
    chk("async_rst_state", {4'h0, state}, 8'h0F);
    chk("async_rst_tdo", {5'h0, tlr, tdo_oe, tdo}, 8'h04);
    wait_clk(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dp_tap_ctrl.md
# dp_tap_ctrl

JTAG TAP controller for the debug port, running entirely in the `iclk` domain. It oversamples the external `tck`/`tms`/`tdi` pins, steps the IEEE 1149.1 16-state TAP FSM on each detected TCK rising edge, and generates the `shift_*`/`clk_*`/`update_*` strobes consumed by the debug instruction-register cells and data-register chains. It also muxes `ir_sdo`/`dr_sdo` onto `tdo` on TCK falling edges.

## Interface
- `SYNC_STAGES`, default 2, number of synchronizer flops per pin input; must be ≥ 2.
- `iclk` in 1: internal clock; must run at ≥ 4× the TCK frequency.
- `iresetn` in 1: reset, asynchronous, active-low; the block is clocked by `iclk`.
- `tck` in 1: JTAG test clock pin, asynchronous to `iclk`.
- `tms` in 1: JTAG mode select pin.
- `tdi` in 1: JTAG data in pin.
- `trstn` in 1: JTAG test reset, active-low; present only with `DP_TAP_TRST_EN`.
- `tdo` out 1: JTAG data out.
- `tdo_oe` out 1: TDO output enable.
- `sdi` out 1: synchronized `tdi` to the IR/DR chain heads.
- `ir_sdo` in 1: serial out of the IR chain tail.
- `dr_sdo` in 1: serial out of the selected DR chain tail.
- `shift_ir` / `clk_ir` / `update_ir` out 1: IR cell controls.
- `shift_dr` / `clk_dr` / `update_dr` out 1: DR cell controls.
- `tlr` out 1: FSM is in Test-Logic-Reset.
- `rti` out 1: FSM is in Run-Test/Idle.
- `state` out 4: current TAP state code.

## Operation
- Synchronizers:
  - Each pin passes through `SYNC_STAGES` flops.
  - Reset values: `tck` 0, `tms` 1, `tdi` 0, `trstn` 0.
  - One extra flop on synchronized tck yields one-cycle pulses `tck_rise` and `tck_fall`. These are mutually exclusive by construction.
- State codes (IEEE encoding):
  - TLR F, RTI C, SEL_DR 7, CAP_DR 6, SH_DR 2, EX1_DR 1, PAU_DR 3, EX2_DR 0, UPD_DR 5.
  - SEL_IR 4, CAP_IR E, SH_IR A, EX1_IR 9, PAU_IR B, EX2_IR 8, UPD_IR D.
- Transitions occur only on `tck_rise`, using synchronized tms. The standard 1149.1 graph applies; for example:
  - TLR: tms=0 → RTI.
  - SEL_IR: tms=1 → TLR.
  - SH_x: tms=1 → EX1_x.
  - UPD_x: tms=0 → RTI, tms=1 → SEL_DR.
- On the `tck_rise` cycle, using the pre-transition state S:
  - `clk_ir` ← S ∈ {CAP_IR, SH_IR}; `shift_ir` ← (S == SH_IR).
  - `clk_dr` ← S ∈ {CAP_DR, SH_DR}; `shift_dr` ← (S == SH_DR).
  - `sdi` ← synchronized tdi.
- `clk_*` is a single-cycle pulse. `shift_*` holds until the next `tck_rise`, so it is stable during its `clk_*` pulse. With `shift_*`=0, a `clk_*` pulse is a capture.
- On the `tck_fall` cycle, using current state S:
  - `update_ir` ← (S == UPD_IR); `update_dr` ← (S == UPD_DR). Each is a single-cycle pulse.
  - `tdo_oe` ← S ∈ {SH_IR, SH_DR}.
  - `tdo` ← `ir_sdo` if S == SH_IR, `dr_sdo` if S == SH_DR, otherwise unchanged.
- `tlr`, `rti` and `state` are registered decodes of the current state.
- tms=1 for 5 consecutive TCK rises reaches TLR from any state.

## Timing
- Reset values:
  - `state` = F, `tlr` = 1.
  - All other outputs 0: `rti`, all strobes, `tdo`, `tdo_oe`, `sdi`.
- Latency from a pin TCK edge to `tck_rise`/`tck_fall`: `SYNC_STAGES`+1 iclk cycles.
- `state`, `clk_*`, `shift_*` and `sdi` update in the cycle after `tck_rise`.
- `update_*`, `tdo` and `tdo_oe` update in the cycle after `tck_fall`.
- An n-bit shift requires entering SH_x, then n−1 rises with tms=0 and 1 rise with tms=1. This gives exactly n shifting `clk_*` pulses; the exit edge shifts.
- TCK high or low phases shorter than 2 iclk periods may be missed. This is unsupported and not checked.
- `iresetn` assertion mid-shift forces the reset values immediately. Chain contents are not touched.

## Configuration
- `DP_TAP_TRST_EN` defined:
  - The `trstn` port exists and is synchronized.
  - While synchronized `trstn`=0: `state` is forced to TLR, all `clk_*`/`update_*`/`shift_*` are cleared, and `tdo_oe` is cleared. This overrides simultaneous `tck_rise`/`tck_fall` events.
- Undefined: no `trstn` port; TAP reset occurs only via `iresetn` or the TMS-high sequence.

## Test plan
- Reset: assert `iresetn`=0 with TCK toggling → `state`=F, `tlr`=1, all strobes 0, `tdo_oe`=0. After release with tms=0, 1 TCK → `state`=C, `rti`=1.
- IR capture: from RTI, tms 1,1,0,0 → states 7,4,E,A. On the rise leaving E, exactly one `clk_ir` pulse with `shift_ir`=0; `shift_ir`=1 from the rise leaving A.
- IR shift/update: in SH_IR, shift 4 bits `tdi`=1,0,1,1 (last with tms=1), then tms 1 → 4 `clk_ir` pulses with `shift_ir`=1. Then one `update_ir` pulse on the falling TCK in state D; `tdo` follows `ir_sdo` on each falling edge.
- DR path: with `ir_sdo`=1 and `dr_sdo`=0 in SH_DR → `tdo`=0, `tdo_oe`=1, `clk_dr` pulses, `clk_ir` never pulses; in RTI → `tdo_oe`=0.
- TMS reset: from SH_DR, tms=1 for 5 TCKs → `state` passes 1,5,7,4,F; `tlr`=1; one `update_dr` pulse occurs in state 5.
- `DP_TAP_TRST_EN`: drive `trstn`=0 mid SH_IR → `state`=F and `shift_ir`=0 within `SYNC_STAGES`+1 cycles; no `update_ir` pulse.
